// File: rtl/conv2d_window_mac_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_window_mac_if
//  Brief    : Kernel-load, window-in and pixel-out bus for conv2d_window_mac.
//  Revision : 1.0  initial release
// ============================================================================
interface conv2d_window_mac_if #(
    parameter int FILT_DIMENSION = 3,
    parameter int BIT_WIDTH      = 16
);
    logic                                                        kernelWrite;
    logic signed [BIT_WIDTH-1:0]                                 kernelData;
    logic                                                        kernelClear;
    logic                                                        kernelLoaded;
    logic                                                        windowValid;
    logic [FILT_DIMENSION-1:0][FILT_DIMENSION-1:0][BIT_WIDTH-1:0] windowMatrix;
    logic                                                        windowReady;
    logic                                                        outValid;
    logic                                                        outReady;
    logic signed [BIT_WIDTH-1:0]                                 outPixel;
    logic                                                        outSaturated;

    modport master (
        output kernelWrite, kernelData, kernelClear, windowValid, windowMatrix, outReady,
        input  kernelLoaded, windowReady, outValid, outPixel, outSaturated
    );

    modport slave (
        input  kernelWrite, kernelData, kernelClear, windowValid, windowMatrix, outReady,
        output kernelLoaded, windowReady, outValid, outPixel, outSaturated
    );
endinterface
`default_nettype wire

// File: rtl/conv2d_window_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_window_mac
//  Brief    : Serially loaded kernel applied to a pixel window; 3-stage
//             multiply / sum / round-saturate pipeline with valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module conv2d_window_mac #(
    parameter int FILT_DIMENSION = 3,
    parameter int BIT_WIDTH      = 16,
    parameter int FRAC_BITS      = 8
) (
    input wire logic             clock,
    input wire logic             reset_n,
    conv2d_window_mac_if.slave   bus
);
    localparam int c_TAPS   = FILT_DIMENSION * FILT_DIMENSION;
    localparam int c_IDX_W  = (c_TAPS > 1) ? $clog2(c_TAPS) : 1;
    localparam int c_PROD_W = 2 * BIT_WIDTH;
    localparam int c_SUM_W  = c_PROD_W + $clog2(c_TAPS);

    localparam logic signed [c_SUM_W-1:0] c_ROUND = c_SUM_W'((64'(1) << FRAC_BITS) >> 1);
    localparam logic signed [c_SUM_W-1:0] c_MAX   = {{(c_SUM_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_MIN   = {{(c_SUM_W-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [c_IDX_W-1:0]           r_idx;
    logic signed [BIT_WIDTH-1:0]  r_coeff [c_TAPS];
    logic                         r_loaded;

    logic signed [c_PROD_W-1:0]   r_prod [c_TAPS];
    logic                         r_v1;
    logic signed [c_SUM_W-1:0]    r_sum;
    logic                         r_v2;
    logic                         r_out_valid;
    logic signed [BIT_WIDTH-1:0]  r_out_pixel;
    logic                         r_out_sat;

    logic                         w_en;
    logic                         w_ready;
    logic                         w_accept;
    logic signed [BIT_WIDTH-1:0]  w_pix [c_TAPS];
    logic signed [c_SUM_W-1:0]    w_sum;
    logic signed [c_SUM_W-1:0]    w_shifted;

    // Output register frees up either when empty or when being consumed.
    assign w_en     = !(r_out_valid && !bus.outReady);
    assign w_ready  = (r_state == ST_RUN) && w_en;
    assign w_accept = bus.windowValid && w_ready;

    generate
        for (genvar r = 0; r < FILT_DIMENSION; r++) begin : g_row
            for (genvar c = 0; c < FILT_DIMENSION; c++) begin : g_col
                assign w_pix[r*FILT_DIMENSION + c] = bus.windowMatrix[r][c];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_loaded <= 1'b0;
            for (int i = 0; i < c_TAPS; i++) r_coeff[i] <= '0;
        end else if (bus.kernelClear) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_loaded <= 1'b0;
            for (int i = 0; i < c_TAPS; i++) r_coeff[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.kernelWrite) begin
                        r_coeff[0] <= bus.kernelData;
                        r_idx      <= c_IDX_W'(1);
                        r_state    <= (c_TAPS == 1) ? ST_RUN : ST_LOAD;
                        r_loaded   <= (c_TAPS == 1);
                    end
                end
                ST_LOAD: begin
                    if (bus.kernelWrite) begin
                        r_coeff[r_idx] <= bus.kernelData;
                        r_idx          <= r_idx + c_IDX_W'(1);
                        if (r_idx == c_IDX_W'(c_TAPS - 1)) begin
                            r_state  <= ST_RUN;
                            r_loaded <= 1'b1;
                        end
                    end
                end
                ST_RUN:  ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_TAPS; i++) begin
            w_sum = w_sum + c_SUM_W'(r_prod[i]);
        end
    end

    // Round half up, then arithmetic shift back to the pixel scale.
    assign w_shifted = (r_sum + c_ROUND) >>> FRAC_BITS;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_out_pixel <= '0;
            r_out_sat   <= 1'b0;
            for (int i = 0; i < c_TAPS; i++) r_prod[i] <= '0;
        end else if (bus.kernelClear) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < c_TAPS; i++) begin
                    r_prod[i] <= $signed({{BIT_WIDTH{w_pix[i][BIT_WIDTH-1]}}, w_pix[i]})
                               * $signed({{BIT_WIDTH{r_coeff[i][BIT_WIDTH-1]}}, r_coeff[i]});
                end
            end
            r_v2 <= r_v1;
            if (r_v1) r_sum <= w_sum;
            r_out_valid <= r_v2;
            if (r_v2) begin
                if (w_shifted > c_MAX) begin
                    r_out_pixel <= c_MAX[BIT_WIDTH-1:0];
                    r_out_sat   <= 1'b1;
                end else if (w_shifted < c_MIN) begin
                    r_out_pixel <= c_MIN[BIT_WIDTH-1:0];
                    r_out_sat   <= 1'b1;
                end else begin
                    r_out_pixel <= w_shifted[BIT_WIDTH-1:0];
                    r_out_sat   <= 1'b0;
                end
            end
        end
    end

    assign bus.kernelLoaded = r_loaded;
    assign bus.windowReady  = w_ready;
    assign bus.outValid     = r_out_valid;
    assign bus.outPixel     = r_out_pixel;
    assign bus.outSaturated = r_out_sat;
endmodule
`default_nettype wire

// File: tb/tb_conv2d_window_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2d_window_mac
//  Brief    : Directed vectors and corner sequences for conv2d_window_mac.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv2d_window_mac;
    localparam int F  = 3;
    localparam int BW = 16;
    localparam int FB = 8;

    typedef logic [8:0][15:0] kern_t;
    typedef struct packed {
        kern_t              k;
        kern_t              w;
        logic signed [15:0] exp;
        logic               sat;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   passed  = 0;

    conv2d_window_mac_if #(.FILT_DIMENSION(F), .BIT_WIDTH(BW)) bus ();

    conv2d_window_mac #(.FILT_DIMENSION(F), .BIT_WIDTH(BW), .FRAC_BITS(FB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic kern_t fill(input int val);
        kern_t f;
        for (int i = 0; i < 9; i++) f[i] = 16'(val);
        return f;
    endfunction

    task automatic set_window(input kern_t w);
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                bus.windowMatrix[r][c] = w[r*F + c];
    endtask

    task automatic do_clear();
        bus.kernelClear = 1'b1;
        tick();
        bus.kernelClear = 1'b0;
    endtask

    task automatic write_coeffs(input kern_t k, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.kernelWrite = 1'b1;
            bus.kernelData  = k[i];
            tick();
        end
        bus.kernelWrite = 1'b0;
    endtask

    task automatic load_kernel(input string name, input kern_t k);
        write_coeffs(k, 0, 9);
        check({name, ".loaded"}, bus.kernelLoaded, 1);
    endtask

    task automatic apply_window(input string name, input kern_t w, input int exp, input int sat);
        int cnt;
        set_window(w);
        bus.windowValid = 1'b1;
        #1;
        check({name, ".rdy"}, bus.windowReady, 1);
        cnt = 0;
        do begin
            tick();
            bus.windowValid = 1'b0;
            cnt++;
        end while (!bus.outValid && cnt < 10);
        check({name, ".lat"}, cnt, 3);
        check({name, ".pix"}, bus.outPixel, exp);
        check({name, ".sat"}, bus.outSaturated, sat);
        tick();
    endtask

    initial begin
        vec_t  vecs [9];
        kern_t kid;
        kern_t w;
        int    got, first, last, j, rcv, stall;
        bit    seen;
        int    expq [$];
        logic signed [15:0] held;

        bus.kernelWrite  = 1'b0;
        bus.kernelData   = '0;
        bus.kernelClear  = 1'b0;
        bus.windowValid  = 1'b0;
        bus.windowMatrix = '0;
        bus.outReady     = 1'b1;

        kid = fill(0);
        kid[4] = 16'd256;

        vecs[0].k = kid;        vecs[0].exp = 16'sd5;
        for (int i = 0; i < 9; i++) vecs[0].w[i] = 16'(i + 1);
        vecs[0].sat = 1'b0;
        vecs[1] = '{k: fill(256), w: fill(1000),   exp: 16'sd9000,   sat: 1'b0};
        vecs[2] = '{k: fill(256), w: fill(30000),  exp: 16'sd32767,  sat: 1'b1};
        vecs[3] = '{k: fill(256), w: fill(-30000), exp: -16'sd32768, sat: 1'b1};
        for (int v = 4; v < 7; v++) begin
            vecs[v].k = fill(0);
            vecs[v].k[4] = 16'd128;
            vecs[v].w = fill(0);
            vecs[v].sat = 1'b0;
        end
        vecs[4].w[4] = 16'(3);  vecs[4].exp = 16'sd2;
        vecs[5].w[4] = 16'(-3); vecs[5].exp = -16'sd1;
        vecs[6].w[4] = 16'(1);  vecs[6].exp = 16'sd1;
        vecs[7] = '{k: fill(-256), w: fill(100), exp: -16'sd900, sat: 1'b0};
        vecs[8].k = fill(0);
        vecs[8].k[0] = 16'd256;
        vecs[8].k[4] = 16'(-128);
        vecs[8].k[8] = 16'd64;
        for (int i = 0; i < 9; i++) vecs[8].w[i] = 16'(10 * (i + 1));
        vecs[8].exp = 16'sd8;
        vecs[8].sat = 1'b0;

        tick();
        tick();
        check("rst.loaded", bus.kernelLoaded, 0);
        check("rst.ready",  bus.windowReady, 0);
        check("rst.valid",  bus.outValid, 0);
        check("rst.pixel",  bus.outPixel, 0);
        check("rst.sat",    bus.outSaturated, 0);
        reset_n = 1'b1;
        tick();
        check("idle.ready", bus.windowReady, 0);

        for (int v = 0; v < 9; v++) begin
            do_clear();
            load_kernel($sformatf("vec%0d", v), vecs[v].k);
            apply_window($sformatf("vec%0d", v), vecs[v].w, int'(vecs[v].exp), int'(vecs[v].sat));
        end

        // Ten back-to-back windows must come out on ten consecutive cycles.
        do_clear();
        load_kernel("stream", fill(256));
        set_window(fill(1000));
        got = 0; first = -1; last = -1;
        for (int t = 0; t < 20; t++) begin
            bus.windowValid = (t < 10);
            tick();
            if (bus.outValid) begin
                check("stream.pix", bus.outPixel, 9000);
                got++;
                if (first < 0) first = t;
                last = t;
            end
        end
        bus.windowValid = 1'b0;
        check("stream.count", got, 10);
        check("stream.span", last - first, 9);

        // Backpressure: five stalled cycles right after the first result.
        do_clear();
        load_kernel("bp", kid);
        j = 0; rcv = 0; stall = 0; seen = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            if (bus.outValid && !seen) begin
                seen  = 1'b1;
                stall = 5;
                held  = bus.outPixel;
            end
            if (stall > 0) begin
                bus.outReady = 1'b0;
                stall--;
            end else begin
                bus.outReady = 1'b1;
            end
            bus.windowValid = (j < 8);
            w = fill(7);
            w[4] = 16'(100 + j);
            set_window(w);
            @(negedge clock);
            if (!bus.outReady) begin
                check("bp.ready", bus.windowReady, 0);
                check("bp.hold", bus.outPixel, held);
            end
            if (bus.windowValid && bus.windowReady) begin
                expq.push_back(100 + j);
                j++;
            end
            if (bus.outValid && bus.outReady) begin
                if (expq.size() == 0) check("bp.extra", 1, 0);
                else check("bp.order", bus.outPixel, expq.pop_front());
                rcv++;
            end
            tick();
        end
        bus.windowValid = 1'b0;
        bus.outReady    = 1'b1;
        check("bp.count", rcv, 8);
        check("bp.sent", j, 8);

        // Clear with two results in flight drops both.
        do_clear();
        load_kernel("clr", kid);
        set_window(vecs[0].w);
        bus.windowValid = 1'b1;
        tick();
        tick();
        bus.windowValid = 1'b0;
        bus.kernelClear = 1'b1;
        tick();
        bus.kernelClear = 1'b0;
        check("clr.valid",  bus.outValid, 0);
        check("clr.loaded", bus.kernelLoaded, 0);
        check("clr.ready",  bus.windowReady, 0);
        tick();
        check("clr.valid2", bus.outValid, 0);
        tick();
        check("clr.valid3", bus.outValid, 0);
        load_kernel("clr.reload", fill(256));
        apply_window("clr.resume", fill(1000), 9000, 0);

        // Asynchronous reset in the middle of a kernel load.
        do_clear();
        write_coeffs(fill(256), 0, 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst.loaded", bus.kernelLoaded, 0);
        check("mrst.ready",  bus.windowReady, 0);
        check("mrst.valid",  bus.outValid, 0);
        check("mrst.pixel",  bus.outPixel, 0);
        check("mrst.sat",    bus.outSaturated, 0);
        tick();
        reset_n = 1'b1;
        tick();
        write_coeffs(fill(256), 0, 8);
        check("mrst.partial", bus.kernelLoaded, 0);
        write_coeffs(fill(256), 8, 1);
        check("mrst.full", bus.kernelLoaded, 1);
        apply_window("mrst.run", fill(1000), 9000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
